// File: rtl/fpu_pkg.sv
// Shared constants for the FPU issue controller: state encoding, fflags bit
// positions and the default decoded-op width.
package fpu_pkg;

    localparam int SFPU_OP_W_DEF = 24;
    localparam int FFLAGS_W      = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        WB    = ST_WB
    } fpu_state_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

endpackage

// File: rtl/fpu_watchdog.sv
// Saturating 8-bit cycle counter for the ISSUE+WAIT window; tc flags the last
// cycle the controller may wait before giving up on the FPU.
module fpu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_l,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'd1;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/wait/writeback sequencer between decode and the FPU datapath, with
// sticky fflags accumulation, flush and a watchdog on FPU completion.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int SFPU_OP_W      = SFPU_OP_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SFPU_OP_W-1:0] in_sfpu_op,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_int,
    input  logic                 flush,
    output logic                 fpu_valid_execution,
    output logic [SFPU_OP_W-1:0] fpu_sfpu_op,
    input  logic [31:0]          fpu_result_1,
    input  logic [31:0]          fpu_result_rd,
    input  logic                 fpu_complete,
    input  logic                 fpu_complete_rd,
    input  logic [4:0]           sflags,
    output logic                 fpr_we,
    output logic                 gpr_we,
    output logic [4:0]           wb_addr,
    output logic [31:0]          wb_data,
    output logic [4:0]           fflags,
    input  logic                 fflags_clr,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [1:0]           dbg_state
);

    // Handshake: an op transfers on a rising edge where in_valid && in_ready;
    // decode must hold its fields stable while in_valid is high and not yet
    // accepted. in_ready is registered and only ever high in IDLE.

    fpu_state_e           state;
    logic [4:0]           rd_q;
    logic                 rd_int_q;
    logic [FFLAGS_W-1:0]  sflags_q;
    logic                 sel_complete;
    logic                 wd_tc;

    assign sel_complete = rd_int_q ? fpu_complete_rd : fpu_complete;
    assign dbg_state    = state;

    fpu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_l (rst_l),
        .load  (state == ISSUE),
        .inc   (state == WAIT),
        .tc    (wd_tc)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state               <= IDLE;
            in_ready            <= 1'b0;
            busy                <= 1'b0;
            fpu_valid_execution <= 1'b0;
            fpu_sfpu_op         <= '0;
            rd_q                <= 5'd0;
            rd_int_q            <= 1'b0;
            sflags_q            <= '0;
            fpr_we              <= 1'b0;
            gpr_we              <= 1'b0;
            wb_addr             <= 5'd0;
            wb_data             <= 32'd0;
            fflags              <= '0;
            timeout_err         <= 1'b0;
        end else begin
            fpu_valid_execution <= 1'b0;
            fpr_we              <= 1'b0;
            gpr_we              <= 1'b0;
            // Clear first, then merge: a clear coinciding with WB keeps the new flags.
            fflags <= (fflags_clr ? '0 : fflags) | ((state == WB) ? sflags_q : '0);

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        fpu_sfpu_op         <= in_sfpu_op;
                        rd_q                <= in_rd;
                        rd_int_q            <= in_rd_int;
                        fpu_valid_execution <= 1'b1;
                        in_ready            <= 1'b0;
                        busy                <= 1'b1;
                        state               <= ISSUE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ISSUE, WAIT: begin
                    // Flush beats a same-cycle completion; the result is dropped.
                    if (flush) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (sel_complete) begin
                        wb_addr  <= rd_q;
                        wb_data  <= rd_int_q ? fpu_result_rd : fpu_result_1;
                        sflags_q <= sflags;
                        fpr_we   <= !rd_int_q;
                        gpr_we   <= rd_int_q;
                        state    <= WB;
                    end else if ((state == WAIT) && wd_tc) begin
                        timeout_err <= 1'b1;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WB: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl: each op's outcome is predicted from the
// completion/flush/timeout rules and writebacks are scored through exp_q.
module tb_fpu_issue_ctrl;

  localparam int SFPU_OP_W = 24;
  localparam int T         = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, in_rd_int, flush;
  logic [SFPU_OP_W-1:0] in_sfpu_op, fpu_sfpu_op;
  logic [4:0]           in_rd, sflags, wb_addr, fflags;
  logic                 fpu_valid_execution, fpu_complete, fpu_complete_rd;
  logic [31:0]          fpu_result_1, fpu_result_rd, wb_data;
  logic                 fpr_we, gpr_we, fflags_clr, busy, timeout_err;
  logic [1:0]           dbg_state;

  fpu_issue_ctrl #(.SFPU_OP_W(SFPU_OP_W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
    .in_sfpu_op(in_sfpu_op), .in_rd(in_rd), .in_rd_int(in_rd_int), .flush(flush),
    .fpu_valid_execution(fpu_valid_execution), .fpu_sfpu_op(fpu_sfpu_op),
    .fpu_result_1(fpu_result_1), .fpu_result_rd(fpu_result_rd),
    .fpu_complete(fpu_complete), .fpu_complete_rd(fpu_complete_rd), .sflags(sflags),
    .fpr_we(fpr_we), .gpr_we(gpr_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];
  logic [4:0]  model_fflags = 5'd0;
  logic        model_tmo = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write-enable cycle must match the oldest expected writeback
  always @(negedge clk) begin
    if (rst_l && (fpr_we || gpr_we)) begin
      if (exp_q.size() == 0)
        check("wb_spurious", 64'({gpr_we, fpr_we, wb_addr, wb_data}), 64'd0);
      else
        check("wb", 64'({gpr_we, fpr_we, wb_addr, wb_data}), 64'(exp_q.pop_front()));
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_sfpu_op = '0; in_rd = 5'd0; in_rd_int = 1'b0; flush = 1'b0;
    fpu_result_1 = 32'd0; fpu_result_rd = 32'd0; fpu_complete = 1'b0;
    fpu_complete_rd = 1'b0; sflags = 5'd0; fflags_clr = 1'b0;
  endtask

  // dly: cycles after ISSUE (0 = in ISSUE) at which the selected completion fires;
  // fl_at: cycle of a flush (-1 = none). Outcome is the earliest of flush,
  // completion, or the T-th cycle of ISSUE+WAIT, with flush beating completion.
  task automatic run_op(input logic [4:0] rd, input logic rd_int, input logic [31:0] data,
                        input int dly, input int fl_at, input logic [4:0] fl, input logic clr_wb);
    logic [SFPU_OP_W-1:0] op;
    logic                 comp;
    int endk, kind;
    op = SFPU_OP_W'($urandom);
    endk = T - 1;
    kind = 2;
    for (int k = 0; k < T; k++) begin
      if (k == fl_at) begin endk = k; kind = 1; break; end
      if (k == dly)   begin endk = k; kind = 0; break; end
    end

    @(negedge clk);
    check("ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_sfpu_op = op; in_rd = rd; in_rd_int = rd_int;
    @(posedge clk);
    for (int k = 0; k <= endk; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_sfpu_op = SFPU_OP_W'($urandom); in_rd = 5'($urandom);
      if (k == 0) begin
        check("issue_strobe", 64'(fpu_valid_execution), 64'd1);
        check("issue_op", 64'(fpu_sfpu_op), 64'(op));
      end else if (k == endk) begin
        check("strobe_low", 64'(fpu_valid_execution), 64'd0);
        check("held_op", 64'(fpu_sfpu_op), 64'(op));
      end
      if (k == endk) check("busy_exec", 64'(busy), 64'd1);
      comp = (kind == 0) && (k == endk);
      if (rd_int) begin
        fpu_complete_rd = comp; fpu_complete = 1'($urandom_range(0, 1));
        fpu_result_rd = comp ? data : $urandom; fpu_result_1 = $urandom;
      end else begin
        fpu_complete = comp; fpu_complete_rd = 1'($urandom_range(0, 1));
        fpu_result_1 = comp ? data : $urandom; fpu_result_rd = $urandom;
      end
      sflags = comp ? fl : 5'($urandom);
      flush = (kind == 1) && (k == endk);
      if (comp) exp_q.push_back({rd_int, !rd_int, rd, data});
      @(posedge clk);
    end
    @(negedge clk);
    fpu_complete = 1'b0; fpu_complete_rd = 1'b0; flush = 1'b0; sflags = 5'($urandom);
    if (kind == 0) begin
      fflags_clr = clr_wb;
      model_fflags = (clr_wb ? 5'd0 : model_fflags) | fl;
      check("wb_busy", 64'(busy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      fflags_clr = 1'b0;
    end else if (kind == 2) begin
      model_tmo = 1'b1;
    end
    check("ready_back", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("fflags", 64'(fflags), 64'(model_fflags));
    check("timeout_err", 64'(timeout_err), 64'(model_tmo));
    check("wb_missing", 64'(exp_q.size()), 64'd0);
    // late completions while idle must not write back
    fpu_complete = 1'($urandom_range(0, 1)); fpu_complete_rd = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    fpu_complete = 1'b0; fpu_complete_rd = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_strobe"}, 64'(fpu_valid_execution), 64'd0);
    check({tag, "_op"}, 64'(fpu_sfpu_op), 64'd0);
    check({tag, "_we"}, 64'({fpr_we, gpr_we}), 64'd0);
    check({tag, "_wb"}, 64'({wb_addr, wb_data}), 64'd0);
    check({tag, "_flags"}, 64'({fflags, timeout_err}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_ready", 64'(in_ready), 64'd1);
    check("post_reset_busy", 64'(busy), 64'd0);

    // directed cases
    run_op(5'd7, 1'b0, 32'h3F800000, 0, -1, 5'b00000, 1'b0);
    run_op(5'd12, 1'b0, 32'h40490FDB, 10, -1, 5'b01000, 1'b0);
    run_op(5'd3, 1'b0, 32'h3EAAAAAB, 2, -1, 5'b00001, 1'b0);
    check("fflags_accum", 64'(fflags), 64'h09);
    run_op(5'd9, 1'b1, 32'h00000001, 3, -1, 5'b00000, 1'b0);
    run_op(5'd4, 1'b0, 32'h12345678, 99, -1, 5'b11111, 1'b0);
    run_op(5'd5, 1'b1, 32'hCAFEF00D, 1, -1, 5'b00010, 1'b0);
    run_op(5'd6, 1'b0, 32'hDEADBEEF, 4, 4, 5'b10100, 1'b0);
    run_op(5'd8, 1'b0, 32'hBF800000, 0, 0, 5'b10100, 1'b0);
    run_op(5'd10, 1'b0, 32'h7F800000, T - 1, -1, 5'b10000, 1'b1);
    check("clr_with_wb", 64'(fflags), 64'h10);

    // randomized ops
    for (int i = 0; i < 150; i++) begin
      int dly, fl_at;
      dly = int'($urandom_range(0, T + 2));
      fl_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, T - 1)) : -1;
      run_op(5'($urandom), 1'($urandom_range(0, 1)), $urandom, dly, fl_at,
             5'($urandom), ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    in_valid = 1'b1; in_rd = 5'd21; in_rd_int = 1'b0; in_sfpu_op = SFPU_OP_W'($urandom);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wait_busy", 64'(busy), 64'd1);
    #2 rst_l = 1'b0;
    #1 check_all_zero("async_reset");
    model_fflags = 5'd0;
    model_tmo = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'd1);
    check("rel_busy", 64'(busy), 64'd0);
    run_op(5'd30, 1'b1, 32'h0000ABCD, 2, -1, 5'b00100, 1'b0);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
